seg_scan_ctrl: RTL

Time-multiplexed driver for the 8-digit seven-segment display. It accepts a 32-bit hex/BCD display word through a valid/ready load port and double-buffers it. It then scans the digits one at a time with a programmable dwell, producing registered `digit` and `seg_data` outputs. It sits downstream of the counter/result logic inside the top-level display path and directly drives the board's digit-select and segment pins.

---
 rtl/seg_scan_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Double-buffered 8-digit seven-segment scan controller with registered outputs.
// Optional build macro SEG_GHOST_GUARD_EN blanks digit select for the first two cycles of each slot.
module seg_scan_ctrl #(
    parameter int SCAN_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [31:0] load_data,
    input  logic [7:0]  blank_mask,
    output logic [7:0]  digit,
    output logic [6:0]  seg_data,
    output logic        frame_done
);

    localparam int PW = $clog2(SCAN_DIV);

    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t        r_state, w_stateNext;
    logic [PW-1:0] r_presc, w_prescNext;
    logic [2:0]    r_index, w_indexNext;
    logic [31:0]   r_active, w_activeNext;
    logic [7:0]    r_activeMask, w_activeMaskNext;
    logic [31:0]   r_pending, w_pendingNext;
    logic [7:0]    r_pendingMask, w_pendingMaskNext;
    logic          r_pendFull, w_pendFullNext;
    logic [7:0]    r_digit, w_digitNext;
    logic [6:0]    r_seg, w_segNext;
    logic          r_frameDone, w_frameDoneNext;
    logic          r_loadReady;
    logic          w_accept;
    logic          w_prescEnd;
    logic [3:0]    w_nibble;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign w_accept   = load_valid && !r_pendFull;
    assign w_prescEnd = (r_presc == PW'(SCAN_DIV - 1));

    always_comb begin
        w_stateNext       = r_state;
        w_prescNext       = r_presc;
        w_indexNext       = r_index;
        w_activeNext      = r_active;
        w_activeMaskNext  = r_activeMask;
        w_pendingNext     = r_pending;
        w_pendingMaskNext = r_pendingMask;
        w_pendFullNext    = r_pendFull;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_stateNext      = ST_SCAN;
                    w_activeNext     = load_data;
                    w_activeMaskNext = blank_mask;
                    w_prescNext      = '0;
                    w_indexNext      = 3'd0;
                end
            end
            default: begin
                if (w_prescEnd) begin
                    w_prescNext = '0;
                    w_indexNext = r_index + 3'd1;
                    // Pending word only swaps in at the frame boundary, never mid-frame
                    if ((r_index == 3'd7) && r_pendFull) begin
                        w_activeNext     = r_pending;
                        w_activeMaskNext = r_pendingMask;
                        w_pendFullNext   = 1'b0;
                    end
                end else begin
                    w_prescNext = r_presc + PW'(1);
                end
                if (w_accept) begin
                    w_pendingNext     = load_data;
                    w_pendingMaskNext = blank_mask;
                    w_pendFullNext    = 1'b1;
                end
            end
        endcase
    end

    assign w_nibble = w_activeNext[{w_indexNext, 2'b00} +: 4];

    // Outputs are computed from next-state values so the registered pins line up with the slot
    always_comb begin
        w_digitNext     = 8'h00;
        w_segNext       = 7'h00;
        w_frameDoneNext = 1'b0;
        if (w_stateNext == ST_SCAN) begin
            w_digitNext     = 8'd1 << w_indexNext;
            w_segNext       = w_activeMaskNext[w_indexNext] ? 7'h00 : hex7(w_nibble);
            w_frameDoneNext = (w_prescNext == PW'(SCAN_DIV - 1)) && (w_indexNext == 3'd7);
`ifdef SEG_GHOST_GUARD_EN
            if (w_prescNext < PW'(2)) begin
                w_digitNext = 8'h00;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_presc       <= '0;
            r_index       <= 3'd0;
            r_active      <= 32'h0;
            r_activeMask  <= 8'h00;
            r_pending     <= 32'h0;
            r_pendingMask <= 8'h00;
            r_pendFull    <= 1'b0;
            r_digit       <= 8'h00;
            r_seg         <= 7'h00;
            r_frameDone   <= 1'b0;
            r_loadReady   <= 1'b1;
        end else begin
            r_state       <= w_stateNext;
            r_presc       <= w_prescNext;
            r_index       <= w_indexNext;
            r_active      <= w_activeNext;
            r_activeMask  <= w_activeMaskNext;
            r_pending     <= w_pendingNext;
            r_pendingMask <= w_pendingMaskNext;
            r_pendFull    <= w_pendFullNext;
            r_digit       <= w_digitNext;
            r_seg         <= w_segNext;
            r_frameDone   <= w_frameDoneNext;
            r_loadReady   <= !w_pendFullNext;
        end
    end

    assign digit      = r_digit;
    assign seg_data   = r_seg;
    assign frame_done = r_frameDone;
    assign load_ready = r_loadReady;

endmodule
